// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths and opcode encodings for the ALU input stage
package alu_pkg;

  localparam int NBITS_DEFAULT  = 8;
  localparam int COD_OP_DEFAULT = 6;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

endpackage

// File: rtl/btn_debouncer.sv
// rtl/btn_debouncer.sv - 2-FF synchronizer, stability counter and press pulse for one button
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // The press pulse is registered alongside the level change, so the load lands one edge later.
  always_comb begin
    deb_d   = deb_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      deb_d   = sync2_q;
      pulse_d = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/alu_input_loader.sv
// rtl/alu_input_loader.sv - latches ALU operands and opcode from switches on debounced presses
module alu_input_loader
  import alu_pkg::*;
#(
  parameter int NBITS           = NBITS_DEFAULT,
  parameter int COD_OP          = COD_OP_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NBITS-1:0]  sw,
  input  logic              btn_A,
  input  logic              btn_B,
  input  logic              btn_OP,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  output logic [2:0]        cargado,
  output logic              datos_validos
);

  logic              pulse_a, pulse_b, pulse_op;
  logic [NBITS-1:0]  sw_s1_q, sw_s2_q;
  logic [NBITS-1:0]  a_q, a_d, b_q, b_d;
  logic [COD_OP-1:0] op_q, op_d;
  logic [2:0]        cargado_q, cargado_d;
  logic              dv_q, dv_d;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_A), .pulse_o(pulse_a)
  );
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_B), .pulse_o(pulse_b)
  );
  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_OP), .pulse_o(pulse_op)
  );

  // All channels sample the same synchronized switch word, so simultaneous presses agree.
  always_comb begin
    a_d       = pulse_a  ? sw_s2_q : a_q;
    b_d       = pulse_b  ? sw_s2_q : b_q;
    op_d      = pulse_op ? sw_s2_q[COD_OP-1:0] : op_q;
    cargado_d = cargado_q | {pulse_op, pulse_b, pulse_a};
    dv_d      = &cargado_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      cargado_q <= '0;
      dv_q      <= 1'b0;
    end else begin
      sw_s1_q   <= sw;
      sw_s2_q   <= sw_s1_q;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      cargado_q <= cargado_d;
      dv_q      <= dv_d;
    end
  end

  assign operando_A    = a_q;
  assign operando_B    = b_q;
  assign cod_operacion = op_q;
  assign cargado       = cargado_q;
  assign datos_validos = dv_q;

endmodule

// File: tb/tb_alu_input_loader.sv
// tb/tb_alu_input_loader.sv - directed scoreboard bench for alu_input_loader
module tb_alu_input_loader;
  import alu_pkg::*;

  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw;
  logic       btn_A, btn_B, btn_OP;
  logic [7:0] operando_A, operando_B;
  logic [5:0] cod_operacion;
  logic [2:0] cargado;
  logic       datos_validos;

  always #5 clk = ~clk;

  alu_input_loader #(.NBITS(8), .COD_OP(6), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw),
    .btn_A(btn_A), .btn_B(btn_B), .btn_OP(btn_OP),
    .operando_A(operando_A), .operando_B(operando_B),
    .cod_operacion(cod_operacion), .cargado(cargado),
    .datos_validos(datos_validos)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [2:0] c;
    logic       dv;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  m;
  int    checks   = 0;
  int    failures = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input exp_t e, input string t);
    sb_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_pop();
    exp_t  e, o;
    string t;
    o = {operando_A, operando_B, cod_operacion, cargado, datos_validos};
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h required=entry", o);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed A=%h B=%h op=%h c=%b dv=%b required A=%h B=%h op=%h c=%b dv=%b",
               t, o.a, o.b, o.op, o.c, o.dv, e.a, e.b, e.op, e.c, e.dv);
      end
    end
  endtask

  // Buttons already driven at this point; sw is assumed synchronized.
  task automatic expect_load(input logic pa, input logic pb, input logic po, input string t);
    exp_t pre, post, fin;
    pre  = m;
    post = m;
    if (pa) post.a  = sw;
    if (pb) post.b  = sw;
    if (po) post.op = sw[5:0];
    post.c  = m.c | {po, pb, pa};
    post.dv = &m.c;
    fin     = post;
    fin.dv  = &post.c;
    push(pre,  {t, "_pre"});
    push(post, {t, "_load"});
    push(fin,  {t, "_dv"});
    m = fin;
    tick(LAT - 1);
    check_pop();
    tick(1);
    check_pop();
    tick(1);
    check_pop();
  endtask

  task automatic press(input logic pa, input logic pb, input logic po,
                       input logic [7:0] s, input string t);
    sw = s;
    tick(3);
    btn_A  = pa;
    btn_B  = pb;
    btn_OP = po;
    expect_load(pa, pb, po, t);
  endtask

  task automatic release_all(input string t);
    btn_A  = 1'b0;
    btn_B  = 1'b0;
    btn_OP = 1'b0;
    push(m, t);
    tick(DB + 4);
    check_pop();
  endtask

  task automatic do_reset(input logic hold, input string t);
    btn_A  = hold;
    btn_B  = hold;
    btn_OP = hold;
    rst_n  = 1'b0;
    m      = '0;
    push(m, t);
    tick(3);
    check_pop();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; sw = 8'h00; btn_A = 1'b0; btn_B = 1'b0; btn_OP = 1'b0;
    m = '0;
    tick(1);

    // 1: reset with all buttons held, then one load of every field
    sw = 8'h3C;
    do_reset(1'b1, "reset_held");
    expect_load(1'b1, 1'b1, 1'b1, "held_at_release");
    sw = 8'h11;
    push(m, "hold_no_reload");
    tick(10);
    check_pop();
    release_all("release_no_load");

    // 2: single A press, other fields untouched, hold then release
    do_reset(1'b0, "reset2");
    press(1'b1, 1'b0, 1'b0, 8'h04, "load_a_04");
    tick(3);
    release_all("a_release");

    // 3: bouncy B never loads
    do_reset(1'b0, "reset3");
    sw = 8'hFF;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      btn_B = 1'b1; tick(2);
      btn_B = 1'b0; tick(2);
    end
    push(m, "bounce_b_ignored");
    tick(12);
    check_pop();

    // 4: full load sequence ending in ADD
    do_reset(1'b0, "reset4");
    press(1'b1, 1'b0, 1'b0, 8'h04, "seq_a");
    release_all("seq_a_rel");
    press(1'b0, 1'b1, 1'b0, 8'h0C, "seq_b");
    release_all("seq_b_rel");
    press(1'b0, 1'b0, 1'b1, 8'h20, "seq_op");
    checks++;
    assert (cod_operacion === ADD) else begin
      failures++;
      $error("FAIL opcode_add observed=%b required=%b", cod_operacion, ADD);
    end
    release_all("seq_op_rel");

    // 5: switch changes while held are ignored; re-press takes new value
    do_reset(1'b0, "reset5");
    press(1'b1, 1'b0, 1'b0, 8'h04, "hold_a_04");
    sw = 8'h55;
    push(m, "held_sw_change");
    tick(10);
    check_pop();
    release_all("hold_a_rel");
    press(1'b1, 1'b0, 1'b0, 8'h55, "repress_a_55");
    release_all("repress_rel");

    // 6: simultaneous A and OP
    do_reset(1'b0, "reset6");
    press(1'b1, 1'b0, 1'b1, 8'hA7, "simul_a_op");
    checks++;
    assert (cod_operacion === NOR) else begin
      failures++;
      $error("FAIL opcode_nor observed=%b required=%b", cod_operacion, NOR);
    end
    release_all("simul_rel");

    // Reset mid-debounce discards progress; held button reloads after release
    do_reset(1'b0, "reset7");
    sw = 8'h5A;
    tick(3);
    btn_A = 1'b1;
    tick(4);
    rst_n = 1'b0;
    push(m, "mid_debounce_reset");
    tick(1);
    check_pop();
    rst_n = 1'b1;
    expect_load(1'b1, 1'b0, 1'b0, "reload_after_reset");
    release_all("final_rel");

    if (sb_q.size() != 0) begin
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
